// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 Hz timing constants and helpers that derive the frame
// totals and sync windows from a set of porch/sync widths.
package vga_timing_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  typedef logic [9:0] coord_t;

  function automatic int unsigned timing_total(input int unsigned active, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // First count of the sync pulse.
  function automatic int unsigned sync_start(input int unsigned active, input int unsigned fp);
    return active + fp;
  endfunction

  // Last count of the sync pulse (inclusive).
  function automatic int unsigned sync_end(input int unsigned active, input int unsigned fp,
                                           input int unsigned sync);
    return active + fp + sync - 1;
  endfunction

endpackage

// File: rtl/vga_scan_generator_divider.sv
// pixel_tick_divider: system-clock to pixel-rate enable. With VGA_DAC_CTRL_EN
// defined it also produces the registered vga_clk for an external video DAC.
module pixel_tick_divider #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
`ifdef VGA_DAC_CTRL_EN
  output logic vga_clk,
`endif
  output logic pix_tick
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  // run_q keeps pix_tick low while in reset even when CLK_DIV=1.
  logic          run_q, run_d;

  always_comb begin
    run_d = 1'b1;
    if (div_cnt_q == DW'(CLK_DIV - 1)) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + DW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
      run_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      run_q     <= run_d;
    end
  end

  assign pix_tick = run_q & (div_cnt_q == DW'(CLK_DIV - 1));

`ifdef VGA_DAC_CTRL_EN
  logic vga_clk_q, vga_clk_d;

  // High for the first half of each pixel period; a plain toggle when CLK_DIV=2.
  always_comb begin
    vga_clk_d = (div_cnt_d < DW'((CLK_DIV + 1) / 2));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_clk_q <= 1'b0;
    end else begin
      vga_clk_q <= vga_clk_d;
    end
  end

  assign vga_clk = vga_clk_q;
`endif

endmodule

// File: rtl/vga_scan_generator.sv
// Free-running VGA raster scan generator: counters, active-low syncs, video_on
// and line/frame markers. Define VGA_DAC_CTRL_EN to add the video DAC outputs.
module vga_scan_generator
  import vga_timing_pkg::*;
#(
  parameter int unsigned CW       = 10,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic          clk,
  input  logic          rst,
  output logic          pix_tick,
  output logic [CW-1:0] h_count,
  output logic [CW-1:0] v_count,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
`ifdef VGA_DAC_CTRL_EN
  output logic          vga_clk,
  output logic          vga_blank_n,
  output logic          vga_sync_n,
`endif
  output logic          line_start,
  output logic          frame_start
);

  localparam int unsigned H_TOTAL  = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL  = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HS_START = sync_start(H_ACTIVE, H_FP);
  localparam int unsigned HS_END   = sync_end(H_ACTIVE, H_FP, H_SYNC);
  localparam int unsigned VS_START = sync_start(V_ACTIVE, V_FP);
  localparam int unsigned VS_END   = sync_end(V_ACTIVE, V_FP, V_SYNC);

  if ((H_TOTAL > (2 ** CW)) || (V_TOTAL > (2 ** CW))) begin : g_timing_too_wide
    $error("vga_scan_generator: H_TOTAL or V_TOTAL does not fit in CW bits");
  end

  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d, video_on_q, video_on_d;

  pixel_tick_divider #(.CLK_DIV(CLK_DIV)) u_div (
    .clk      (clk),
    .rst      (rst),
`ifdef VGA_DAC_CTRL_EN
    .vga_clk  (vga_clk),
`endif
    .pix_tick (pix_tick)
  );

  // Syncs and video_on derive from the next counts so they stay aligned with them.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_tick) begin
      if (h_q == CW'(H_TOTAL - 1)) begin
        h_d = '0;
        if (v_q == CW'(V_TOTAL - 1)) begin
          v_d = '0;
        end else begin
          v_d = v_q + CW'(1);
        end
      end else begin
        h_d = h_q + CW'(1);
      end
    end else begin
      h_d = h_q;
    end
    hsync_d    = !((h_d >= CW'(HS_START)) && (h_d <= CW'(HS_END)));
    vsync_d    = !((v_d >= CW'(VS_START)) && (v_d <= CW'(VS_END)));
    video_on_d = (h_d < CW'(H_ACTIVE)) && (v_d < CW'(V_ACTIVE));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q        <= CW'(H_TOTAL - 1);
      v_q        <= CW'(V_TOTAL - 1);
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      video_on_q <= 1'b0;
    end else begin
      h_q        <= h_d;
      v_q        <= v_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      video_on_q <= video_on_d;
    end
  end

  assign h_count     = h_q;
  assign v_count     = v_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign line_start  = pix_tick & (h_q == '0);
  assign frame_start = line_start & (v_q == '0);

`ifdef VGA_DAC_CTRL_EN
  assign vga_blank_n = video_on_q;
  assign vga_sync_n  = 1'b1;
`endif

endmodule

// File: tb/tb_vga_scan_generator.sv
// Scoreboard bench: three scan generators (small timing CLK_DIV=2 and =1,
// default 640x480) checked every clock against a position-arithmetic model.
module tb_vga_scan_generator;

  localparam int SH_A = 16, SH_FP = 2, SH_S = 3, SH_BP = 3;
  localparam int SV_A = 8,  SV_FP = 1, SV_S = 2, SV_BP = 2;

  typedef struct {
    logic tick; int h; int v; logic hs; logic vs; logic von; logic ls; logic fs; logic vclk;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic       tick [3];
  logic [9:0] hc   [3];
  logic [9:0] vc   [3];
  logic       hs   [3];
  logic       vs   [3];
  logic       von  [3];
  logic       ls   [3];
  logic       fs   [3];
`ifdef VGA_DAC_CTRL_EN
  logic       vclk [3];
  logic       blank_n [3];
  logic       sync_n  [3];
`endif

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   n      = 0;
  int   cyc    = 0;
  int   last_fs [2] = '{-1, -1};

  always #5 clk = ~clk;

  vga_scan_generator #(.CW(10), .CLK_DIV(2), .H_ACTIVE(SH_A), .H_FP(SH_FP), .H_SYNC(SH_S),
    .H_BP(SH_BP), .V_ACTIVE(SV_A), .V_FP(SV_FP), .V_SYNC(SV_S), .V_BP(SV_BP)) u_a (
    .clk(clk), .rst(rst), .pix_tick(tick[0]), .h_count(hc[0]), .v_count(vc[0]),
    .hsync(hs[0]), .vsync(vs[0]), .video_on(von[0]),
`ifdef VGA_DAC_CTRL_EN
    .vga_clk(vclk[0]), .vga_blank_n(blank_n[0]), .vga_sync_n(sync_n[0]),
`endif
    .line_start(ls[0]), .frame_start(fs[0]));

  vga_scan_generator #(.CW(10), .CLK_DIV(1), .H_ACTIVE(SH_A), .H_FP(SH_FP), .H_SYNC(SH_S),
    .H_BP(SH_BP), .V_ACTIVE(SV_A), .V_FP(SV_FP), .V_SYNC(SV_S), .V_BP(SV_BP)) u_b (
    .clk(clk), .rst(rst), .pix_tick(tick[1]), .h_count(hc[1]), .v_count(vc[1]),
    .hsync(hs[1]), .vsync(vs[1]), .video_on(von[1]),
`ifdef VGA_DAC_CTRL_EN
    .vga_clk(vclk[1]), .vga_blank_n(blank_n[1]), .vga_sync_n(sync_n[1]),
`endif
    .line_start(ls[1]), .frame_start(fs[1]));

  vga_scan_generator u_c (
    .clk(clk), .rst(rst), .pix_tick(tick[2]), .h_count(hc[2]), .v_count(vc[2]),
    .hsync(hs[2]), .vsync(vs[2]), .video_on(von[2]),
`ifdef VGA_DAC_CTRL_EN
    .vga_clk(vclk[2]), .vga_blank_n(blank_n[2]), .vga_sync_n(sync_n[2]),
`endif
    .line_start(ls[2]), .frame_start(fs[2]));

  // Reference: after n clock edges since reset release, the scan has advanced a
  // known number of pixels from the (H_TOTAL-1, V_TOTAL-1) reset position.
  function automatic exp_t model(input int nn, input int d, input int ha, input int hf,
                                 input int hsw, input int hb, input int va, input int vf,
                                 input int vsw, input int vb);
    exp_t e;
    int ht, vt, adv, lin;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    if (nn == 0) begin
      e.tick = 1'b0; e.h = ht - 1; e.v = vt - 1; e.vclk = 1'b0;
    end else begin
      e.tick = ((nn % d) == d - 1);
      adv    = nn / d - ((d == 1) ? 1 : 0);
      lin    = (ht * vt - 1 + adv) % (ht * vt);
      e.h    = lin % ht;
      e.v    = lin / ht;
      e.vclk = ((nn % d) < (d + 1) / 2);
    end
    e.hs  = !((e.h >= ha + hf) && (e.h < ha + hf + hsw));
    e.vs  = !((e.v >= va + vf) && (e.v < va + vf + vsw));
    e.von = (e.h < ha) && (e.v < va);
    e.ls  = e.tick && (e.h == 0);
    e.fs  = e.ls && (e.v == 0);
    return e;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %0d expected %0d", nm, k, $time, act, exp);
    end
  endtask

  // One clock of stimulus: optionally change rst just after the edge, then
  // queue what every DUT should show before the next edge.
  task automatic step(input logic new_rst);
    @(posedge clk);
    if (!rst) n++;
    #2 rst = new_rst;
    if (rst) n = 0;
    #1;
    sb_q.push_back(model(n, 2, SH_A, SH_FP, SH_S, SH_BP, SV_A, SV_FP, SV_S, SV_BP));
    sb_q.push_back(model(n, 1, SH_A, SH_FP, SH_S, SH_BP, SV_A, SV_FP, SV_S, SV_BP));
    sb_q.push_back(model(n, 2, 640, 16, 96, 48, 480, 10, 2, 33));
  endtask

  // Monitor: pops one expectation per DUT on every falling edge.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    while (sb_q.size() >= 3) begin
      for (int k = 0; k < 3; k++) begin
        e = sb_q.pop_front();
        chk("pix_tick",    k, tick[k], e.tick);
        chk("h_count",     k, hc[k],   e.h);
        chk("v_count",     k, vc[k],   e.v);
        chk("hsync",       k, hs[k],   e.hs);
        chk("vsync",       k, vs[k],   e.vs);
        chk("video_on",    k, von[k],  e.von);
        chk("line_start",  k, ls[k],   e.ls);
        chk("frame_start", k, fs[k],   e.fs);
`ifdef VGA_DAC_CTRL_EN
        chk("vga_clk",     k, vclk[k],    e.vclk);
        chk("vga_blank_n", k, blank_n[k], e.von);
        chk("vga_sync_n",  k, sync_n[k],  1);
`endif
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        last_fs[k] = -1;
      end else if (fs[k] === 1'b1) begin
        if (last_fs[k] >= 0)
          chk("frame_period", k, cyc - last_fs[k],
              (SH_A + SH_FP + SH_S + SH_BP) * (SV_A + SV_FP + SV_S + SV_BP) * ((k == 0) ? 2 : 1));
        last_fs[k] = cyc;
      end
    end
  end

  initial begin
    rst = 1'b1;
    repeat (3) step(1'b1);
    step(1'b0);
    repeat (3500) step(1'b0);
    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(20, 800)) step(1'b0);
      step(1'b1);
      repeat ($urandom_range(0, 3)) step(1'b1);
      step(1'b0);
    end
    repeat (700) step(1'b0);
    @(negedge clk);
    #1;
    chk("scoreboard_drain", 0, sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
